// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes, grant
// codes and the latency counter width.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LDR  = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester picker for the memory port arbiter.
// Build option ARB_FIXED_PRIO_EN: when defined the loader wins every tie
// (used to starve the CPU during boot load); otherwise ties alternate
// away from the previous winner.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_ldr_req,
  input  logic [1:0] i_last_grant,
  output logic [1:0] o_grant
);

`ifdef ARB_FIXED_PRIO_EN
  // Previous winner is irrelevant with fixed priority.
  logic w_unused_last;
  assign w_unused_last = ^i_last_grant;
`endif

  // Choose the winner among the active requests.
  always_comb begin
    o_grant = GNT_NONE;
    if (i_cpu_req && i_ldr_req) begin
`ifdef ARB_FIXED_PRIO_EN
      o_grant = GNT_LDR;
`else
      o_grant = (i_last_grant == GNT_CPU) ? GNT_LDR : GNT_CPU;
`endif
    end else if (i_cpu_req) begin
      o_grant = GNT_CPU;
    end else if (i_ldr_req) begin
      o_grant = GNT_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the CPU core and the
// program loader. Each access runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles)
// -> RESP, so one access completes every MEM_LAT+3 cycles.
// Build option ARB_FIXED_PRIO_EN (see arb_pick2) selects loader-wins ties.
//
// state  | meaning
// IDLE   | no owner; pick a winner and capture its command
// ACCESS | mem_en strobe with captured command; load latency counter
// WAIT   | count down memory latency; latch read data on terminal count
// RESP   | one-cycle ack to the winner; remember it for round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant_o,
  output logic          busy_o
);

  logic [1:0]       r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_cpu_rdata;
  logic [DW-1:0]    r_ldr_rdata;
  logic [1:0]       w_pick;
  logic             w_rd_done;

  arb_pick2 u_pick (
    .i_cpu_req    (cpu_req),
    .i_ldr_req    (ldr_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick)
  );

  // Read completes on the last WAIT cycle of a read access.
  assign w_rd_done = (r_state == ST_WAIT) && (r_cnt == '0) && !r_we;

  // Sequencing FSM, command capture at grant and latency down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_NONE;
      r_last_grant <= GNT_LDR;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick != GNT_NONE) begin
            r_grant <= w_pick;
            r_we    <= (w_pick == GNT_CPU) ? cpu_we    : ldr_we;
            r_addr  <= (w_pick == GNT_CPU) ? cpu_addr  : ldr_addr;
            r_wdata <= (w_pick == GNT_CPU) ? cpu_wdata : ldr_wdata;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_cnt   <= CNT_W'(MEM_LAT - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_last_grant <= r_grant;
          r_grant      <= GNT_NONE;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data lands only in the winner's register; writes leave both alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else if (w_rd_done) begin
      if (r_grant == GNT_CPU) begin
        r_cpu_rdata <= mem_rdata;
      end else begin
        r_ldr_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_ack   = (r_state == ST_RESP) && (r_grant == GNT_CPU);
  assign ldr_ack   = (r_state == ST_RESP) && (r_grant == GNT_LDR);
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign grant_o   = r_grant;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at
// MEM_LAT=3. Inputs are driven and outputs sampled on the falling edge.
// Expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_LDR  = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, ldr_ack, mem_en, mem_we, busy;
  logic [1:0]  grant;

  logic        d3_cpu_req, d3_cpu_we, d3_ldr_req, d3_ldr_we;
  logic [31:0] d3_cpu_addr, d3_cpu_wdata, d3_ldr_addr, d3_ldr_wdata, d3_mem_rdata;
  logic [31:0] d3_cpu_rdata, d3_ldr_rdata, d3_mem_addr, d3_mem_wdata;
  logic        d3_cpu_ack, d3_ldr_ack, d3_mem_en, d3_mem_we, d3_busy;
  logic [1:0]  d3_grant;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  logic [31:0] exp_cpu, exp_ldr;
  logic [1:0]  w;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_o(grant), .busy_o(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
    .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack),
    .ldr_req(d3_ldr_req), .ldr_we(d3_ldr_we), .ldr_addr(d3_ldr_addr), .ldr_wdata(d3_ldr_wdata),
    .ldr_rdata(d3_ldr_rdata), .ldr_ack(d3_ldr_ack),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata), .grant_o(d3_grant), .busy_o(d3_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; mem_rdata = 0;
    d3_cpu_req = 0; d3_cpu_we = 0; d3_cpu_addr = 0; d3_cpu_wdata = 0;
    d3_ldr_req = 0; d3_ldr_we = 0; d3_ldr_addr = 0; d3_ldr_wdata = 0; d3_mem_rdata = 0;

    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, G_NONE);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_acks", {cpu_ack, ldr_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // CPU read alone at 0x40
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    step();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_grant", grant, G_CPU);
    chk("t1_busy", busy, 1);
    chk("t1_ack_c1", cpu_ack, 0);
    mem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_wait_en", mem_en, 0);
    chk("t1_wait_addr", mem_addr, 32'h40);
    chk("t1_ack_c2", cpu_ack, 0);
    step();
    chk("t1_ack_c3", cpu_ack, 1);
    chk("t1_ldr_ack", ldr_ack, 0);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_ldr_rdata", ldr_rdata, 0);
    cpu_req = 0;
    step();
    chk("t1_ack_c4", cpu_ack, 0);
    chk("t1_grant_clr", grant, G_NONE);
    chk("t1_busy_clr", busy, 0);
    exp_cpu = 32'hDEADBEEF;
    exp_ldr = 32'h0;

    // Loader write 0x100 <- 0x12345678
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100; ldr_wdata = 32'h12345678;
    mem_rdata = 32'hCAFE0000;
    step();
    chk("t2_mem_en", mem_en, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_grant", grant, G_LDR);
    step();
    chk("t2_wait_we", mem_we, 0);
    step();
    chk("t2_ldr_ack", ldr_ack, 1);
    chk("t2_cpu_ack", cpu_ack, 0);
    chk("t2_cpu_rdata", cpu_rdata, exp_cpu);
    chk("t2_ldr_rdata", ldr_rdata, exp_ldr);
    ldr_req = 0; ldr_we = 0;
    step();
    chk("t2_busy_clr", busy, 0);

    // Both requests held for four accesses
    cpu_req = 1; ldr_req = 1; cpu_addr = 32'h200; ldr_addr = 32'h300;
    for (int c = 1; c <= 15; c++) begin
      step();
`ifdef ARB_FIXED_PRIO_EN
      w = G_LDR;
`else
      w = (((c - 1) / 4) % 2 == 0) ? G_CPU : G_LDR;
`endif
      case ((c - 1) % 4)
        0: begin
          chk("t3_grant", grant, w);
          chk("t3_mem_en", mem_en, 1);
          chk("t3_mem_addr", mem_addr, (w == G_CPU) ? 32'h200 : 32'h300);
          chk("t3_acc_acks", {cpu_ack, ldr_ack}, 0);
          mem_rdata = 32'hA0000000 + 32'((c - 1) / 4);
        end
        1: begin
          chk("t3_wait_en", mem_en, 0);
          chk("t3_wait_acks", {cpu_ack, ldr_ack}, 0);
        end
        2: begin
          chk("t3_cpu_ack", cpu_ack, (w == G_CPU));
          chk("t3_ldr_ack", ldr_ack, (w == G_LDR));
          if (w == G_CPU) exp_cpu = mem_rdata;
          else            exp_ldr = mem_rdata;
          chk("t3_cpu_rdata", cpu_rdata, exp_cpu);
          chk("t3_ldr_rdata", ldr_rdata, exp_ldr);
          if (c == 15) begin
            cpu_req = 0; ldr_req = 0;
          end
        end
        default: begin
          chk("t3_idle_grant", grant, G_NONE);
          chk("t3_idle_busy", busy, 0);
          chk("t3_idle_acks", {cpu_ack, ldr_ack}, 0);
        end
      endcase
    end
    step();
    chk("t3_end_busy", busy, 0);

    // CPU write; inputs change right after the grant edge
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h55;
    step();
    cpu_addr = 32'hFFF; cpu_wdata = 32'hAAAA; mem_rdata = 32'h77777777;
    chk("t4_mem_addr", mem_addr, 32'h80);
    chk("t4_mem_wdata", mem_wdata, 32'h55);
    chk("t4_mem_we", mem_we, 1);
    chk("t4_grant", grant, G_CPU);
    step();
    chk("t4_wait_addr", mem_addr, 32'h80);
    step();
    chk("t4_cpu_ack", cpu_ack, 1);
    chk("t4_cpu_rdata", cpu_rdata, exp_cpu);
    chk("t4_ldr_rdata", ldr_rdata, exp_ldr);
    cpu_req = 0; cpu_we = 0;
    step();

    // MEM_LAT=3 instance: data must come from the third WAIT cycle
    d3_cpu_req = 1; d3_cpu_addr = 32'h44;
    step();
    chk("t6_mem_en", d3_mem_en, 1);
    chk("t6_mem_addr", d3_mem_addr, 32'h44);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("t6_wait_en", d3_mem_en, 0);
      chk("t6_wait_ack", d3_cpu_ack, 0);
      chk("t6_wait_busy", d3_busy, 1);
      d3_mem_rdata = 32'h11111111 * 32'(c);
    end
    step();
    d3_mem_rdata = 32'h55555555;
    chk("t6_ack", d3_cpu_ack, 1);
    chk("t6_cpu_rdata", d3_cpu_rdata, 32'h44444444);
    chk("t6_ldr_rdata", d3_ldr_rdata, 0);
    d3_cpu_req = 0;
    step();
    chk("t6_ack_clr", d3_cpu_ack, 0);
    chk("t6_busy_clr", d3_busy, 0);

    // Reset pulsed during WAIT
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h300;
    step();
    chk("t5_grant", grant, G_LDR);
    step();
    mem_rdata = 32'h99999999;
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_grant_rst", grant, G_NONE);
    chk("t5_mem_en", mem_en, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_wdata", mem_wdata, 0);
    chk("t5_rdata", {cpu_rdata, ldr_rdata}, 0);
    chk("t5_acks", {cpu_ack, ldr_ack}, 0);
    ldr_req = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_no_ack", ldr_ack, 0);
    end
    reset = 1'b1;
    step();
    chk("t5_post_ack", ldr_ack, 0);
    cpu_req = 1; ldr_req = 1; cpu_addr = 32'h10; ldr_addr = 32'h20;
`ifdef ARB_FIXED_PRIO_EN
    w = G_LDR;
`else
    w = G_CPU;
`endif
    step();
    chk("t5_first_grant", grant, w);
    chk("t5_first_addr", mem_addr, (w == G_CPU) ? 32'h10 : 32'h20);
    step();
    step();
    chk("t5_cpu_ack", cpu_ack, (w == G_CPU));
    chk("t5_ldr_ack", ldr_ack, (w == G_LDR));
    cpu_req = 0; ldr_req = 0;
    step();
    chk("t5_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
